// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-source writeback arbiter for the register file write port
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb0_valid,
  input  logic [4:0]  wb0_addr,
  input  logic [31:0] wb0_data,
  output logic        wb0_ready,
  input  logic        wb1_valid,
  input  logic [4:0]  wb1_addr,
  input  logic [31:0] wb1_data,
  output logic        wb1_ready,
  input  logic        set_en,
  input  logic [4:0]  set_addr,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] busy,
  output logic        set_err
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] scnt;
  logic             starved;
  logic             grant0;
  logic             grant1;
  logic             xfer;
  logic [4:0]       win_addr;
  logic [31:0]      win_data;
  logic [31:0]      set_mask;
  logic [31:0]      clr_mask;
  logic             set_hit_busy;

  // Grant selection: port 0 has priority unless port 1 has waited STARVE_LIMIT grants.
  // Both grants are forced low while reset is held so nothing is accepted then.
  always_comb begin
    starved      = (scnt >= LIMIT);
    grant1       = !rst && wb1_valid && (!wb0_valid || starved);
    grant0       = !rst && wb0_valid && !grant1;
    xfer         = grant0 || grant1;
    win_addr     = grant1 ? wb1_addr : wb0_addr;
    win_data     = grant1 ? wb1_data : wb0_data;
    set_mask     = (set_en && (set_addr != 5'd0)) ? (32'd1 << set_addr) : 32'd0;
    clr_mask     = grant1 ? (32'd1 << wb1_addr) : 32'd0;
    // A set on a bit that is busy and not simultaneously retiring is a double issue.
    set_hit_busy = |(set_mask & busy & ~clr_mask);
  end

  assign wb0_ready = grant0;
  assign wb1_ready = grant1;

  // Starvation counter: counts port-0 wins while port 1 is waiting, saturating at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt <= '0;
    end else if (!wb1_valid || grant1) begin
      scnt <= '0;
    end else if (grant0 && (scnt < LIMIT)) begin
      scnt <= scnt + CNT_W'(1);
    end
  end

  // Register-file write stage: one-cycle strobe per accepted nonzero-destination write.
  // Address/data hold their previous value when no write is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else begin
      rf_we <= xfer && (win_addr != 5'd0);
      if (xfer && (win_addr != 5'd0)) begin
        rf_waddr <= win_addr;
        rf_wdata <= win_data;
      end
    end
  end

  // Busy scoreboard: port-1 retirement clears, issue sets, set wins on the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 32'd0;
      set_err <= 1'b0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
      if (set_hit_busy) begin
        set_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  localparam int LIM = 3;

  logic        clk;
  logic        rst;
  logic        wb0_valid;
  logic [4:0]  wb0_addr;
  logic [31:0] wb0_data;
  logic        wb0_ready;
  logic        wb1_valid;
  logic [4:0]  wb1_addr;
  logic [31:0] wb1_data;
  logic        wb1_ready;
  logic        set_en;
  logic [4:0]  set_addr;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy;
  logic        set_err;

  int checks = 0;
  int errors = 0;

  // model state
  int          mscnt;
  logic [31:0] mbusy;
  logic        merr;
  logic        dut_g1;
  logic [36:0] exp_q[$];

  regfile_wb_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .set_en(set_en), .set_addr(set_addr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .set_err(set_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write monitor: every rf_we strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got addr=%0d data=%h expected none", rf_waddr, rf_wdata);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          if ({rf_waddr, rf_wdata} !== e) begin
            errors++;
            $display("FAIL write_value got addr=%0d data=%h expected addr=%0d data=%h",
                     rf_waddr, rf_wdata, e[36:32], e[31:0]);
          end
        end
      end else if (exp_q.size() != 0) begin
        logic [36:0] e;
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_write got rf_we=0 expected addr=%0d data=%h", e[36:32], e[31:0]);
      end
    end
  end

  task automatic model_reset();
    mscnt = 0;
    mbusy = 32'd0;
    merr  = 1'b0;
    exp_q.delete();
  endtask

  // one cycle: drive at negedge, check readies, push expected write, then check scoreboard
  task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic se, input logic [4:0] sa);
    logic g0, g1;
    logic [31:0] clr, setm;
    wb0_valid = v0; wb0_addr = a0; wb0_data = d0;
    wb1_valid = v1; wb1_addr = a1; wb1_data = d1;
    set_en = se; set_addr = sa;
    #1;
    g1 = v1 && (!v0 || mscnt == LIM);
    g0 = v0 && !g1;
    dut_g1 = wb1_ready;
    checks++;
    if (wb0_ready !== g0 || wb1_ready !== g1) begin
      errors++;
      $display("FAIL ready got r0=%b r1=%b expected r0=%b r1=%b", wb0_ready, wb1_ready, g0, g1);
    end
    if (g0 && a0 != 5'd0) exp_q.push_back({a0, d0});
    if (g1 && a1 != 5'd0) exp_q.push_back({a1, d1});
    clr  = g1 ? (32'd1 << a1) : 32'd0;
    setm = (se && sa != 5'd0) ? (32'd1 << sa) : 32'd0;
    if (se && sa != 5'd0 && mbusy[sa] && !(g1 && a1 == sa)) merr = 1'b1;
    @(posedge clk);
    mbusy = (mbusy & ~clr) | setm;
    if (!v1 || g1) mscnt = 0;
    else if (g0 && mscnt < LIM) mscnt = mscnt + 1;
    @(negedge clk);
    checks++;
    if (busy !== mbusy || set_err !== merr) begin
      errors++;
      $display("FAIL scoreboard got busy=%h err=%b expected busy=%h err=%b", busy, set_err, mbusy, merr);
    end
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wb0_valid = 1'b1; wb0_addr = 5'd1; wb0_data = 32'h1;
    wb1_valid = 1'b1; wb1_addr = 5'd2; wb1_data = 32'h2;
    set_en = 1'b0; set_addr = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || busy !== 32'd0 || set_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got we=%b wa=%0d wd=%h busy=%h err=%b expected all 0",
               rf_we, rf_waddr, rf_wdata, busy, set_err);
    end
    checks++;
    if (wb0_ready !== 1'b0 || wb1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got r0=%b r1=%b expected 0 0", wb0_ready, wb1_ready);
    end
    rst = 1'b0;
    model_reset();
    idle();
  endtask

  task automatic test_single_write();
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_write got we=%b wa=%0d wd=%h expected 1 5 deadbeef", rf_we, rf_waddr, rf_wdata);
    end
    idle();
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_write_hold got we=%b wa=%0d wd=%h expected 0 5 deadbeef", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_reg_zero();
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);
    checks++;
    if (dut_g1 !== 1'b1 || rf_we !== 1'b0 || busy !== 32'd0) begin
      errors++;
      $display("FAIL reg_zero got r1=%b we=%b busy=%h expected 1 0 0", dut_g1, rf_we, busy);
    end
    idle();
  endtask

  task automatic test_contention();
    logic [7:0] seq;
    seq = 8'd0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 5'(i + 1), 32'h1000 + 32'(i), 1'b1, 5'd3, 32'hAAAA5555, 1'b0, 5'd0);
      seq[i] = dut_g1;
    end
    checks++;
    if (seq !== 8'b1000_1000) begin
      errors++;
      $display("FAIL contention_pattern got %b expected 10001000", seq);
    end
    idle();
  endtask

  task automatic test_same_cycle_set_clear();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0FFEE, 1'b1, 5'd12);
    checks++;
    if (busy[12] !== 1'b1 || set_err !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle got busy12=%b err=%b expected 1 0", busy[12], set_err);
    end
    // retire register 12 so the next test starts from an empty scoreboard
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0FFEF, 1'b0, 5'd0);
  endtask

  task automatic test_scoreboard();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    checks++;
    if (busy !== 32'h0000_0080) begin
      errors++;
      $display("FAIL busy_set got %h expected 00000080", busy);
    end
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd9);
    checks++;
    if (busy !== 32'h0000_0200) begin
      errors++;
      $display("FAIL busy_set_clear got %h expected 00000200", busy);
    end
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    idle();
    checks++;
    if (set_err !== 1'b1 || busy !== 32'h0000_0200) begin
      errors++;
      $display("FAIL set_err_sticky got err=%b busy=%h expected 1 00000200", set_err, busy);
    end
  endtask

  task automatic test_reset_mid_op();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd10, 32'h5000 + 32'(i), 1'b1, 5'd3, 32'h33, 1'b1, 5'(4 + i));
    end
    #2;
    checks++;
    if (rf_we !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup got rf_we=%b expected 1", rf_we);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rf_we !== 1'b0 || busy !== 32'd0 || set_err !== 1'b0 || wb0_ready !== 1'b0 || wb1_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got we=%b busy=%h err=%b r0=%b r1=%b expected all 0",
               rf_we, busy, set_err, wb0_ready, wb1_ready);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // starvation count was at the limit before reset; port 0 must win again now
    step(1'b1, 5'd11, 32'hB0B0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0);
    checks++;
    if (dut_g1 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_arb got r1=%b expected 0", dut_g1);
    end
    idle();
    idle();
  endtask

  initial begin
    model_reset();
    dut_g1 = 1'b0;
    test_reset();
    test_single_write();
    test_reg_zero();
    test_contention();
    test_same_cycle_set_clear();
    test_scoreboard();
    test_reset_mid_op();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
